// File: rtl/coverage.sv
// rtl/coverage.sv - RVVI retirement-trace functional coverage collector (hart 0, slot 0)
module coverage #(
  parameter int ILEN   = 32,
  parameter int XLEN   = 64,
  parameter int FLEN   = 64,
  parameter int VLEN   = 256,
  parameter int NHART  = 1,
  parameter int RETIRE = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [ILEN-1:0]  insn,
  input  logic             trap,
  input  logic [XLEN-1:0]  pc_rdata,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] trap_count,
  output logic [CNT_W-1:0] unknown_count,
  output logic [16:0]      opcode_hit,
  output logic [31:0]      rd_hit,
  output logic [31:0]      rs1_hit,
  output logic [31:0]      rs2_hit,
  output logic [XLEN-1:0]  last_pc,
  output logic             all_covered
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Opcode-class bin positions within opcode_hit[15:0]
  localparam int B_LOAD      = 0;
  localparam int B_LOAD_FP   = 1;
  localparam int B_MISC_MEM  = 2;
  localparam int B_OP_IMM    = 3;
  localparam int B_AUIPC     = 4;
  localparam int B_OP_IMM_32 = 5;
  localparam int B_STORE     = 6;
  localparam int B_STORE_FP  = 7;
  localparam int B_AMO       = 8;
  localparam int B_OP        = 9;
  localparam int B_LUI       = 10;
  localparam int B_OP_32     = 11;
  localparam int B_BRANCH    = 12;
  localparam int B_JALR      = 13;
  localparam int B_JAL       = 14;
  localparam int B_SYSTEM    = 15;

  // Registered coverage state
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;
  logic [CNT_W-1:0] unknown_count_q, unknown_count_d;
  logic [16:0]      opcode_hit_q, opcode_hit_d;
  logic [31:0]      rd_hit_q, rd_hit_d;
  logic [31:0]      rs1_hit_q, rs1_hit_d;
  logic [31:0]      rs2_hit_q, rs2_hit_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;

  // Decode results for the instruction currently on the trace
  logic        is_32bit;
  logic        op_known;
  logic [15:0] cls_hit;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;

  // funct3/funct7 and the interface-parity parameters play no part in binning
  logic unused_cfg;
  assign unused_cfg = ^{insn[ILEN-1:25], insn[14:12],
                        (FLEN > 0), (VLEN > 0), (NHART > 0), (RETIRE > 0)};

  assign is_32bit = (insn[1:0] == 2'b11);
  assign rd_idx   = insn[11:7];
  assign rs1_idx  = insn[19:15];
  assign rs2_idx  = insn[24:20];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // Classify the major opcode and decide which register fields are architecturally meaningful
  always_comb begin
    cls_hit  = '0;
    op_known = 1'b1;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (insn[6:0])
      7'b0000011: begin cls_hit[B_LOAD]      = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0000111: begin cls_hit[B_LOAD_FP]   = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0001111: begin cls_hit[B_MISC_MEM]  = 1'b1; end
      7'b0010011: begin cls_hit[B_OP_IMM]    = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0010111: begin cls_hit[B_AUIPC]     = 1'b1; use_rd = 1'b1; end
      7'b0011011: begin cls_hit[B_OP_IMM_32] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0100011: begin cls_hit[B_STORE]     = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0100111: begin cls_hit[B_STORE_FP]  = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0101111: begin
        cls_hit[B_AMO] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0110011: begin
        cls_hit[B_OP] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0110111: begin cls_hit[B_LUI]       = 1'b1; use_rd = 1'b1; end
      7'b0111011: begin
        cls_hit[B_OP_32] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: begin cls_hit[B_BRANCH]    = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100111: begin cls_hit[B_JALR]      = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'b1101111: begin cls_hit[B_JAL]       = 1'b1; use_rd = 1'b1; end
      7'b1110011: begin cls_hit[B_SYSTEM]    = 1'b1; use_rd = 1'b1; end
      default:    begin op_known = 1'b0; end
    endcase
  end

  // Next-state: clear dominates; a valid sample counts, then trap/compressed/unknown/binned
  always_comb begin
    sample_count_d  = sample_count_q;
    trap_count_d    = trap_count_q;
    unknown_count_d = unknown_count_q;
    opcode_hit_d    = opcode_hit_q;
    rd_hit_d        = rd_hit_q;
    rs1_hit_d       = rs1_hit_q;
    rs2_hit_d       = rs2_hit_q;
    last_pc_d       = last_pc_q;
    if (clear) begin
      sample_count_d  = '0;
      trap_count_d    = '0;
      unknown_count_d = '0;
      opcode_hit_d    = '0;
      rd_hit_d        = '0;
      rs1_hit_d       = '0;
      rs2_hit_d       = '0;
      last_pc_d       = '0;
    end else if (valid) begin
      sample_count_d = sat_inc(sample_count_q);
      last_pc_d      = pc_rdata;
      if (trap) begin
        trap_count_d = sat_inc(trap_count_q);
      end else if (!is_32bit) begin
        opcode_hit_d[16] = 1'b1;
      end else if (!op_known) begin
        unknown_count_d = sat_inc(unknown_count_q);
      end else begin
        opcode_hit_d[15:0] = opcode_hit_q[15:0] | cls_hit;
        if (use_rd)  rd_hit_d  = rd_hit_q  | (32'd1 << rd_idx);
        if (use_rs1) rs1_hit_d = rs1_hit_q | (32'd1 << rs1_idx);
        if (use_rs2) rs2_hit_d = rs2_hit_q | (32'd1 << rs2_idx);
      end
    end
  end

  // State register; reset clears everything without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count_q  <= '0;
      trap_count_q    <= '0;
      unknown_count_q <= '0;
      opcode_hit_q    <= '0;
      rd_hit_q        <= '0;
      rs1_hit_q       <= '0;
      rs2_hit_q       <= '0;
      last_pc_q       <= '0;
    end else begin
      sample_count_q  <= sample_count_d;
      trap_count_q    <= trap_count_d;
      unknown_count_q <= unknown_count_d;
      opcode_hit_q    <= opcode_hit_d;
      rd_hit_q        <= rd_hit_d;
      rs1_hit_q       <= rs1_hit_d;
      rs2_hit_q       <= rs2_hit_d;
      last_pc_q       <= last_pc_d;
    end
  end

  assign sample_count  = sample_count_q;
  assign trap_count    = trap_count_q;
  assign unknown_count = unknown_count_q;
  assign opcode_hit    = opcode_hit_q;
  assign rd_hit        = rd_hit_q;
  assign rs1_hit       = rs1_hit_q;
  assign rs2_hit       = rs2_hit_q;
  assign last_pc       = last_pc_q;
  assign all_covered   = (&opcode_hit_q[15:0]) & (&rd_hit_q) & (&rs1_hit_q) & (&rs2_hit_q);

endmodule

// File: tb/tb_coverage.sv
// tb/tb_coverage.sv - randomized self-checking bench for coverage against a behavioural model
module tb_coverage;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        valid;
  logic [31:0] insn;
  logic        trap;
  logic [63:0] pc_rdata;

  logic [31:0] sample_count, trap_count, unknown_count;
  logic [16:0] opcode_hit;
  logic [31:0] rd_hit, rs1_hit, rs2_hit;
  logic [63:0] last_pc;
  logic        all_covered;

  logic [3:0]  s4_sample, s4_trap, s4_unknown;
  logic [16:0] s4_opcode_hit;
  logic [31:0] s4_rd_hit, s4_rs1_hit, s4_rs2_hit;
  logic [63:0] s4_last_pc;
  logic        s4_all_covered;

  coverage dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .insn(insn), .trap(trap),
    .pc_rdata(pc_rdata), .sample_count(sample_count), .trap_count(trap_count),
    .unknown_count(unknown_count), .opcode_hit(opcode_hit), .rd_hit(rd_hit),
    .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .last_pc(last_pc), .all_covered(all_covered)
  );

  coverage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .insn(insn), .trap(trap),
    .pc_rdata(pc_rdata), .sample_count(s4_sample), .trap_count(s4_trap),
    .unknown_count(s4_unknown), .opcode_hit(s4_opcode_hit), .rd_hit(s4_rd_hit),
    .rs1_hit(s4_rs1_hit), .rs2_hit(s4_rs2_hit), .last_pc(s4_last_pc),
    .all_covered(s4_all_covered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the opcode table and the per-role class lists, straight from the bin rules
  logic [6:0] op_tab [16] = '{7'b0000011, 7'b0000111, 7'b0001111, 7'b0010011,
                              7'b0010111, 7'b0011011, 7'b0100011, 7'b0100111,
                              7'b0101111, 7'b0110011, 7'b0110111, 7'b0111011,
                              7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};
  int rd_cls[$]  = '{0, 1, 3, 4, 5, 8, 9, 10, 11, 13, 14, 15};
  int rs1_cls[$] = '{0, 1, 3, 5, 6, 7, 8, 9, 11, 12, 13};
  int rs2_cls[$] = '{6, 7, 8, 9, 11, 12};

  longint      m_samples, m_traps, m_unk;
  bit          m_op [17];
  bit          m_rd [32];
  bit          m_rs1 [32];
  bit          m_rs2 [32];
  logic [63:0] m_pc;

  function automatic int class_of(input logic [6:0] op);
    for (int k = 0; k < 16; k++) if (op_tab[k] == op) return k;
    return -1;
  endfunction

  function automatic bit in_list(input int q[$], input int v);
    foreach (q[k]) if (q[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] pack32(input bit a [32]);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = a[k];
    return r;
  endfunction

  function automatic logic [16:0] pack_op();
    logic [16:0] r;
    for (int k = 0; k < 17; k++) r[k] = m_op[k];
    return r;
  endfunction

  function automatic logic exp_all_covered();
    for (int k = 0; k < 16; k++) if (!m_op[k]) return 1'b0;
    for (int k = 0; k < 32; k++) if (!m_rd[k] || !m_rs1[k] || !m_rs2[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_zero();
    m_samples = 0; m_traps = 0; m_unk = 0; m_pc = '0;
    foreach (m_op[k]) m_op[k] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      m_rd[k] = 1'b0; m_rs1[k] = 1'b0; m_rs2[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int c;
    if (clear) begin
      model_zero();
    end else if (valid) begin
      m_samples++;
      m_pc = pc_rdata;
      if (trap) m_traps++;
      else if (insn[1:0] != 2'b11) m_op[16] = 1'b1;
      else begin
        c = class_of(insn[6:0]);
        if (c < 0) m_unk++;
        else begin
          m_op[c] = 1'b1;
          if (in_list(rd_cls, c))  m_rd[insn[11:7]]   = 1'b1;
          if (in_list(rs1_cls, c)) m_rs1[insn[19:15]] = 1'b1;
          if (in_list(rs2_cls, c)) m_rs2[insn[24:20]] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".samples"}, 64'(sample_count), 64'(sat(m_samples, 32)));
    check({tag, ".traps"},   64'(trap_count),   64'(sat(m_traps, 32)));
    check({tag, ".unknown"}, 64'(unknown_count), 64'(sat(m_unk, 32)));
    check({tag, ".opcode"},  64'(opcode_hit), 64'(pack_op()));
    check({tag, ".rd"},      64'(rd_hit),  64'(pack32(m_rd)));
    check({tag, ".rs1"},     64'(rs1_hit), 64'(pack32(m_rs1)));
    check({tag, ".rs2"},     64'(rs2_hit), 64'(pack32(m_rs2)));
    check({tag, ".last_pc"}, last_pc, m_pc);
    check({tag, ".all_cov"}, 64'(all_covered), 64'(exp_all_covered()));
    check({tag, ".s4_samples"}, 64'(s4_sample),  64'(sat(m_samples, 4)));
    check({tag, ".s4_traps"},   64'(s4_trap),    64'(sat(m_traps, 4)));
    check({tag, ".s4_unknown"}, 64'(s4_unknown), 64'(sat(m_unk, 4)));
  endtask

  // Drive one cycle at the falling edge, let the design sample, compare at the next falling edge
  task automatic step(input string tag, input logic v, input logic [31:0] i, input logic t,
                      input logic [63:0] pc, input logic clr);
    valid = v; insn = i; trap = t; pc_rdata = pc; clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  logic [31:0] w;
  int          r;

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; insn = '0; trap = 1'b0; pc_rdata = '0;
    model_zero();
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Idle cycles with valid low
    for (int k = 0; k < 10; k++) step("idle", 1'b0, $urandom, 1'b0, {$urandom, $urandom}, 1'b0);
    check("idle.all_cov_const", 64'(all_covered), 64'd0);

    // add x5,x6,x7
    step("add", 1'b1, 32'h007302B3, 1'b0, 64'h8000_0000, 1'b0);
    check("add.samples_const", 64'(sample_count), 64'd1);
    check("add.opcode_const",  64'(opcode_hit), 64'h200);
    check("add.regs_const", {rd_hit[5], rs1_hit[6], rs2_hit[7]}, 64'd7);
    check("add.pc_const", last_pc, 64'h8000_0000);

    // Trapped ecall updates only sample/trap counters
    step("clr1", 1'b0, '0, 1'b0, '0, 1'b1);
    step("ecall", 1'b1, 32'h0000_0073, 1'b1, 64'h8000_0004, 1'b0);
    check("ecall.traps_const", 64'(trap_count), 64'd1);
    check("ecall.bins_const", {rd_hit, rs1_hit, rs2_hit, opcode_hit} == '0, 64'd1);

    // Unlisted opcode then compressed c.li
    step("clr2", 1'b0, '0, 1'b0, '0, 1'b1);
    step("unk", 1'b1, 32'h0000_007F, 1'b0, 64'h100, 1'b0);
    step("cli", 1'b1, 32'h0000_4501, 1'b0, 64'h104, 1'b0);
    check("cli.unknown_const", 64'(unknown_count), 64'd1);
    check("cli.opcode_const",  64'(opcode_hit), 64'h10000);
    check("cli.samples_const", 64'(sample_count), 64'd2);

    // Full-coverage stream: every class, then every register index through OP
    step("clr3", 1'b0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      w = $urandom;
      w[6:0] = op_tab[c];
      step("cls", 1'b1, w, 1'b0, 64'(c * 4), 1'b0);
    end
    for (int k = 0; k < 32; k++) begin
      w = {7'd0, 5'(k), 5'(k), 3'd0, 5'(k), 7'b0110011};
      step("regs", 1'b1, w, 1'b0, 64'(k), 1'b0);
    end
    check("full.all_cov_const", 64'(all_covered), 64'd1);
    step("clr_sample", 1'b1, 32'h007302B3, 1'b0, 64'hDEAD, 1'b1);
    check("clr_sample.samples_const", 64'(sample_count), 64'd0);
    check("clr_sample.pc_const", last_pc, 64'd0);

    // Randomized mixed traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      w = $urandom;
      if (r < 70) w[6:0] = op_tab[$urandom_range(0, 15)];
      else if (r < 85) w[1:0] = 2'b11;
      else w[1:0] = 2'($urandom_range(0, 2));
      step("rand", ($urandom_range(0, 9) < 8), w, ($urandom_range(0, 9) == 0),
           {$urandom, $urandom}, ($urandom_range(0, 99) < 2));
    end

    // Counter saturation at CNT_W=4, then asynchronous reset between edges
    step("clr4", 1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 20; k++) step("sat", 1'b1, 32'h0000_0073, 1'b1, 64'(k), 1'b0);
    check("sat.s4_samples_const", 64'(s4_sample), 64'hF);
    check("sat.s4_traps_const",   64'(s4_trap),   64'hF);
    valid = 1'b1; insn = 32'h007302B3; trap = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async.samples", 64'(sample_count), 64'd0);
    check("async.s4_samples", 64'(s4_sample), 64'd0);
    check("async.last_pc", last_pc, 64'd0);
    model_zero();
    @(negedge clk);
    compare_all("async_hold");
    rst_n = 1'b1;
    step("after_rst", 1'b1, 32'h007302B3, 1'b0, 64'h42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
